// File: rtl/pit_timer_if.sv
// CPU register port of the interval timer: write/read strobes, address, data,
// plus the interrupt request and its acknowledge.
interface pit_timer_if #(
  parameter int WIDTH = 32
);
  logic             WR_EN;
  logic             RD_EN;
  logic [1:0]       ADDR;
  logic [WIDTH-1:0] WR_DATA;
  logic [WIDTH-1:0] RD_DATA;
  logic             IRQ;
  logic             IRQ_ACK;

  modport master (
    output WR_EN, RD_EN, ADDR, WR_DATA, IRQ_ACK,
    input  RD_DATA, IRQ
  );

  modport slave (
    input  WR_EN, RD_EN, ADDR, WR_DATA, IRQ_ACK,
    output RD_DATA, IRQ
  );
endinterface

// File: rtl/pit_timer.sv
// Programmable interval timer: counts down from LOAD, flags expiry as a pending
// interrupt, optionally reloads, and exposes CTRL/LOAD/COUNT/STATUS to the CPU.
module pit_timer #(
  parameter int WIDTH = 32
) (
  input  logic       CLOCK,
  input  logic       RST,
  pit_timer_if.slave bus
);
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic             enable_reg, enable_next;
  logic             irq_en_reg, irq_en_next;
  logic             auto_reload_reg, auto_reload_next;
  logic             pending_reg, pending_next;
  logic [WIDTH-1:0] load_reg, load_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;

  logic wr_ctrl, wr_load, wr_status;
  logic expiry, clear_req;

  assign wr_ctrl   = bus.WR_EN && (bus.ADDR == ADDR_CTRL);
  assign wr_load   = bus.WR_EN && (bus.ADDR == ADDR_LOAD);
  assign wr_status = bus.WR_EN && (bus.ADDR == ADDR_STATUS);

  // COUNT==0 is the idle state, so a zero LOAD never produces an expiry.
  assign expiry    = enable_reg && (count_reg == WIDTH'(1));
  assign clear_req = bus.IRQ_ACK || (wr_status && bus.WR_DATA[0]);

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      enable_reg      <= 1'b0;
      irq_en_reg      <= 1'b0;
      auto_reload_reg <= 1'b0;
      pending_reg     <= 1'b0;
      load_reg        <= '0;
      count_reg       <= '0;
      rd_data_reg     <= '0;
    end else begin
      enable_reg      <= enable_next;
      irq_en_reg      <= irq_en_next;
      auto_reload_reg <= auto_reload_next;
      pending_reg     <= pending_next;
      load_reg        <= load_next;
      count_reg       <= count_next;
      rd_data_reg     <= rd_data_next;
    end
  end

  always_comb begin
    enable_next      = enable_reg;
    irq_en_next      = irq_en_reg;
    auto_reload_next = auto_reload_reg;
    pending_next     = pending_reg;
    load_next        = load_reg;
    count_next       = count_reg;
    rd_data_next     = rd_data_reg;

    if (enable_reg) begin
      if (count_reg > WIDTH'(1)) begin
        count_next = count_reg - WIDTH'(1);
      end else if (expiry) begin
        if (auto_reload_reg) begin
          count_next = load_reg;
        end else begin
          count_next  = '0;
          enable_next = 1'b0;
        end
      end
    end

    // Expiry is applied after the clear so a same-cycle set wins.
    if (clear_req) pending_next = 1'b0;
    if (expiry)    pending_next = 1'b1;

    // CPU writes come last so they override the counter's own updates.
    if (wr_ctrl) begin
      enable_next      = bus.WR_DATA[0];
      irq_en_next      = bus.WR_DATA[1];
      auto_reload_next = bus.WR_DATA[2];
    end
    if (wr_load) begin
      load_next  = bus.WR_DATA;
      count_next = bus.WR_DATA;
    end

    if (bus.RD_EN) begin
      case (bus.ADDR)
        ADDR_CTRL:   rd_data_next = {{(WIDTH-3){1'b0}}, auto_reload_reg, irq_en_reg, enable_reg};
        ADDR_LOAD:   rd_data_next = load_reg;
        ADDR_COUNT:  rd_data_next = count_reg;
        default:     rd_data_next = {{(WIDTH-1){1'b0}}, pending_reg};
      endcase
    end
  end

  assign bus.RD_DATA = rd_data_reg;
  assign bus.IRQ     = pending_reg & irq_en_reg;
endmodule

// File: tb/tb_pit_timer.sv
// Directed bench for pit_timer: a register-level model tracks every cycle and is
// compared on each falling edge; directed reads pin hand-computed values.
module tb_pit_timer;
  logic CLOCK = 1'b0;
  logic RST   = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pit_timer_if #(.WIDTH(32)) bus ();

  pit_timer #(.WIDTH(32)) dut (
    .CLOCK (CLOCK),
    .RST   (RST),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  // Model state: the programmer-visible registers.
  bit          model_valid = 1'b0;
  bit          m_en, m_ie, m_ar, m_pend;
  logic [31:0] m_load, m_count, m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge CLOCK) begin
    bit          fired, en, ie, ar, p;
    logic [31:0] c, ld, r;
    if (RST) begin
      model_valid <= 1'b1;
      {m_en, m_ie, m_ar, m_pend} <= '0;
      m_load <= '0; m_count <= '0; m_rd <= '0;
    end else begin
      fired = m_en && (m_count == 1);
      en = m_en; ie = m_ie; ar = m_ar; ld = m_load; c = m_count; r = m_rd;
      if (m_en && m_count > 1) c = m_count - 1;
      if (fired) begin
        c  = m_ar ? m_load : 32'd0;
        en = m_ar;
      end
      p = (m_pend && !(bus.IRQ_ACK || (bus.WR_EN && bus.ADDR == 2'd3 && bus.WR_DATA[0]))) || fired;
      if (bus.RD_EN)
        r = (bus.ADDR == 2'd0) ? {29'd0, m_ar, m_ie, m_en} :
            (bus.ADDR == 2'd1) ? m_load :
            (bus.ADDR == 2'd2) ? m_count : {31'd0, m_pend};
      if (bus.WR_EN && bus.ADDR == 2'd0) {ar, ie, en} = bus.WR_DATA[2:0];
      if (bus.WR_EN && bus.ADDR == 2'd1) begin ld = bus.WR_DATA; c = bus.WR_DATA; end
      m_en <= en; m_ie <= ie; m_ar <= ar; m_pend <= p;
      m_load <= ld; m_count <= c; m_rd <= r;
    end
  end

  always @(negedge CLOCK) begin
    if (model_valid) begin
      check("model_irq", {31'd0, bus.IRQ}, {31'd0, m_pend & m_ie});
      check("model_rd_data", bus.RD_DATA, m_rd);
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.WR_EN = 1'b1; bus.ADDR = a; bus.WR_DATA = d;
    tick();
    bus.WR_EN = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.RD_EN = 1'b1; bus.ADDR = a;
    tick();
    bus.RD_EN = 1'b0;
    check(name, bus.RD_DATA, exp);
  endtask

  task automatic ack();
    bus.IRQ_ACK = 1'b1;
    tick();
    bus.IRQ_ACK = 1'b0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    check(name, {31'd0, bus.IRQ}, {31'd0, exp});
  endtask

  initial begin
    bus.WR_EN = 1'b0; bus.RD_EN = 1'b0; bus.ADDR = 2'd0;
    bus.WR_DATA = '0; bus.IRQ_ACK = 1'b0;
    RST = 1'b1;
    repeat (2) tick();
    check("reset_rd_data", bus.RD_DATA, 32'd0);
    check_irq(1'b0, "reset_irq");
    RST = 1'b0;
    rd(2'd0, 32'd0, "reset_ctrl");
    rd(2'd1, 32'd0, "reset_load");
    rd(2'd2, 32'd0, "reset_count");
    rd(2'd3, 32'd0, "reset_status");

    // LOAD=0 never fires; writes to COUNT are ignored.
    wr(2'd0, 32'd7);
    repeat (5) tick();
    rd(2'd3, 32'd0, "load0_no_expiry");
    wr(2'd2, 32'd9);
    rd(2'd2, 32'd0, "count_write_ignored");
    wr(2'd0, 32'd0);
    bus.RD_EN = 1'b1; bus.WR_EN = 1'b1; bus.ADDR = 2'd1; bus.WR_DATA = 32'd11;
    tick();
    bus.RD_EN = 1'b0; bus.WR_EN = 1'b0;
    check("rw_same_cycle_old", bus.RD_DATA, 32'd0);
    rd(2'd1, 32'd11, "rw_same_cycle_new");

    // 1: auto-reload period of 5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd7);
    rd(2'd2, 32'd5, "t1_count5");
    rd(2'd2, 32'd4, "t1_count4");
    rd(2'd2, 32'd3, "t1_count3");
    rd(2'd2, 32'd2, "t1_count2");
    check_irq(1'b0, "t1_irq_before");
    rd(2'd2, 32'd1, "t1_count1");
    check_irq(1'b1, "t1_irq_after");
    rd(2'd2, 32'd5, "t1_reload5");
    wr(2'd0, 32'd0);
    ack();
    check_irq(1'b0, "t1_irq_acked");

    // 2: one-shot; then CTRL write on the expiry edge keeps enable.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd3);
    repeat (3) tick();
    check_irq(1'b1, "t2_irq");
    rd(2'd2, 32'd0, "t2_count0");
    rd(2'd0, 32'd2, "t2_ctrl_cleared");
    ack();
    check_irq(1'b0, "t2_irq_acked");
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd3);
    tick();
    wr(2'd0, 32'd3);
    rd(2'd0, 32'd3, "t2_ctrl_write_wins");
    wr(2'd0, 32'd0);
    ack();

    // 3: ack on the exact expiry edge; LOAD write on expiry edge.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd7);
    tick();
    ack();
    check_irq(1'b1, "t3_set_wins");
    tick();
    wr(2'd1, 32'd9);
    rd(2'd2, 32'd9, "t3_load_write_wins");
    rd(2'd3, 32'd1, "t3_pending");
    wr(2'd0, 32'd0);
    ack();

    // 4: masked interrupt, unmask, W1C.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'd5);
    repeat (2) tick();
    check_irq(1'b0, "t4_masked");
    rd(2'd3, 32'd1, "t4_status");
    wr(2'd0, 32'd7);
    check_irq(1'b1, "t4_unmasked");
    wr(2'd3, 32'd1);
    check_irq(1'b0, "t4_w1c");
    wr(2'd0, 32'd0);
    ack();

    // 5: LOAD write while running, freeze, resume.
    wr(2'd1, 32'd30);
    wr(2'd0, 32'd1);
    repeat (23) tick();
    wr(2'd1, 32'd20);
    rd(2'd2, 32'd20, "t5_load_while_running");
    wr(2'd0, 32'd0);
    repeat (10) tick();
    rd(2'd2, 32'd18, "t5_frozen");
    wr(2'd0, 32'd1);
    tick();
    rd(2'd2, 32'd17, "t5_resumed");

    // 6: reset mid-count with pending set.
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd7);
    repeat (6) tick();
    rd(2'd3, 32'd1, "t6_pending_before");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_irq(1'b0, "t6_irq_reset");
    check("t6_rd_data_reset", bus.RD_DATA, 32'd0);
    rd(2'd2, 32'd0, "t6_count_reset");
    rd(2'd0, 32'd0, "t6_ctrl_reset");
    rd(2'd1, 32'd0, "t6_load_reset");
    rd(2'd3, 32'd0, "t6_status_reset");

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
